// File: rtl/sound_i2s_rx.sv
// I2S receiver: oversamples SCLK/LRCK/DATA in the clk_74a domain, frames 32-bit slots and
// emits each locked left/right pair with a one-cycle valid strobe.
module sound_i2s_rx #(
    parameter int unsigned CHANNEL_WIDTH = 15,
    parameter bit          SIGNED_OUTPUT = 1'b0,
    parameter int unsigned SCLK_TIMEOUT  = 256
) (
    input  logic                     clk_74a,
    input  logic                     reset_n,
    input  logic                     i2s_sclk,
    input  logic                     i2s_lrck,
    input  logic                     i2s_data,
    output logic [CHANNEL_WIDTH-1:0] audio_l,
    output logic [CHANNEL_WIDTH-1:0] audio_r,
    output logic                     audio_valid,
    output logic                     locked,
    output logic                     frame_err
);

    localparam int unsigned TW = $clog2(SCLK_TIMEOUT + 1);

    if (CHANNEL_WIDTH < 1 || CHANNEL_WIDTH > 16) begin : g_bad_width
        $error("sound_i2s_rx: CHANNEL_WIDTH must be 1..16");
    end
    if (CHANNEL_WIDTH == 16 && !SIGNED_OUTPUT) begin : g_bad_map
        $error("sound_i2s_rx: CHANNEL_WIDTH=16 requires SIGNED_OUTPUT=1");
    end

    typedef enum logic [1:0] {StIdle, StSync, StRun} state_e;

    // [0] metastable stage, [1] synced, [2] history
    logic [2:0] sclk_q, sclk_d;
    logic [2:0] lrck_q, lrck_d;
    logic [2:0] data_q, data_d;

    state_e                   state_q, state_d;
    logic                     lrck_prev_q, lrck_prev_d;
    logic [5:0]               bit_cnt_q, bit_cnt_d;
    logic [15:0]              shift_q, shift_d;
    logic [5:0]               prev_len_q, prev_len_d;
    logic                     prev_valid_q, prev_valid_d;
    logic [15:0]              pend_l_q, pend_l_d;
    logic                     pend_l_valid_q, pend_l_valid_d;
    logic                     locked_q, locked_d;
    logic [CHANNEL_WIDTH-1:0] audio_l_q, audio_l_d;
    logic [CHANNEL_WIDTH-1:0] audio_r_q, audio_r_d;
    logic                     valid_q, valid_d;
    logic                     ferr_q, ferr_d;
    logic [TW-1:0]            to_cnt_q, to_cnt_d;

    logic        strobe;
    logic        lrck_s;
    logic        data_s;
    logic        boundary;
    logic        lock_now;
    logic [5:0]  cnt_inc;
    logic [15:0] shift_in;

    function automatic logic [CHANNEL_WIDTH-1:0] map_word(input logic [15:0] w);
        logic [15:0] a;
        a = SIGNED_OUTPUT ? w : {w[14:0], 1'b0};
        return a[15 -: CHANNEL_WIDTH];
    endfunction

    // LRCK/DATA taken from the history stage: the value just before the synced SCLK rise.
    assign strobe   = sclk_q[1] & ~sclk_q[2];
    assign lrck_s   = lrck_q[2];
    assign data_s   = data_q[2];
    assign boundary = lrck_s != lrck_prev_q;
    assign cnt_inc  = (bit_cnt_q == 6'd63) ? 6'd63 : bit_cnt_q + 6'd1;
    assign shift_in = (bit_cnt_q < 6'd16) ? {shift_q[14:0], data_s} : shift_q;

    always_comb begin
        sclk_d         = {sclk_q[1:0], i2s_sclk};
        lrck_d         = {lrck_q[1:0], i2s_lrck};
        data_d         = {data_q[1:0], i2s_data};
        state_d        = state_q;
        lrck_prev_d    = lrck_prev_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        prev_len_d     = prev_len_q;
        prev_valid_d   = prev_valid_q;
        pend_l_d       = pend_l_q;
        pend_l_valid_d = pend_l_valid_q;
        locked_d       = locked_q;
        audio_l_d      = audio_l_q;
        audio_r_d      = audio_r_q;
        valid_d        = 1'b0;
        ferr_d         = 1'b0;
        lock_now       = locked_q;

        if (strobe) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != TW'(SCLK_TIMEOUT)) begin
            to_cnt_d = to_cnt_q + TW'(1);
        end else begin
            to_cnt_d = to_cnt_q;
        end

        if (strobe) begin
            lrck_prev_d = lrck_s;
            unique case (state_q)
                StIdle: state_d = StSync;
                StSync: begin
                    // The slot in progress at start-up is never trusted.
                    if (boundary) begin
                        state_d   = StRun;
                        bit_cnt_d = '0;
                        shift_d   = '0;
                    end
                end
                StRun: begin
                    if (!boundary) begin
                        bit_cnt_d = cnt_inc;
                        shift_d   = shift_in;
                    end else begin
                        bit_cnt_d = '0;
                        shift_d   = '0;
                        if (cnt_inc < 6'd16) begin
                            ferr_d         = 1'b1;
                            locked_d       = 1'b0;
                            pend_l_valid_d = 1'b0;
                            prev_valid_d   = 1'b0;
                        end else begin
                            lock_now     = locked_q | (prev_valid_q && prev_len_q == cnt_inc);
                            locked_d     = lock_now;
                            prev_len_d   = cnt_inc;
                            prev_valid_d = 1'b1;
                            if (!lrck_prev_q) begin
                                pend_l_d       = shift_in;
                                pend_l_valid_d = 1'b1;
                            end else begin
                                if (pend_l_valid_q && lock_now) begin
                                    audio_l_d = map_word(pend_l_q);
                                    audio_r_d = map_word(shift_in);
                                    valid_d   = 1'b1;
                                end
                                pend_l_valid_d = 1'b0;
                            end
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end else if (to_cnt_q == TW'(SCLK_TIMEOUT)) begin
            locked_d       = 1'b0;
            pend_l_valid_d = 1'b0;
            prev_valid_d   = 1'b0;
            state_d        = StIdle;
        end
    end

    always_ff @(posedge clk_74a) begin
        if (!reset_n) begin
            sclk_q         <= '0;
            lrck_q         <= '0;
            data_q         <= '0;
            state_q        <= StIdle;
            lrck_prev_q    <= 1'b0;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            prev_len_q     <= '0;
            prev_valid_q   <= 1'b0;
            pend_l_q       <= '0;
            pend_l_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            audio_l_q      <= '0;
            audio_r_q      <= '0;
            valid_q        <= 1'b0;
            ferr_q         <= 1'b0;
            to_cnt_q       <= '0;
        end else begin
            sclk_q         <= sclk_d;
            lrck_q         <= lrck_d;
            data_q         <= data_d;
            state_q        <= state_d;
            lrck_prev_q    <= lrck_prev_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            prev_len_q     <= prev_len_d;
            prev_valid_q   <= prev_valid_d;
            pend_l_q       <= pend_l_d;
            pend_l_valid_q <= pend_l_valid_d;
            locked_q       <= locked_d;
            audio_l_q      <= audio_l_d;
            audio_r_q      <= audio_r_d;
            valid_q        <= valid_d;
            ferr_q         <= ferr_d;
            to_cnt_q       <= to_cnt_d;
        end
    end

    assign audio_l     = audio_l_q;
    assign audio_r     = audio_r_q;
    assign audio_valid = valid_q;
    assign locked      = locked_q;
    assign frame_err   = ferr_q;

endmodule

// File: tb/tb_sound_i2s_rx.sv
// Scoreboard bench for sound_i2s_rx: three mappings share one directed I2S stream.
module tb_sound_i2s_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n = 1'b0;
    logic sclk = 1'b0;
    logic lrck = 1'b0;
    logic data = 1'b0;

    logic [14:0] l15, r15;
    logic [15:0] l16, r16;
    logic [11:0] l12, r12;
    logic        v15, v16, v12, lk15, lk16, lk12, fe15, fe16, fe12;

    sound_i2s_rx #(.CHANNEL_WIDTH(15), .SIGNED_OUTPUT(1'b0), .SCLK_TIMEOUT(256)) u_dut (
        .clk_74a(clk), .reset_n(reset_n), .i2s_sclk(sclk), .i2s_lrck(lrck), .i2s_data(data),
        .audio_l(l15), .audio_r(r15), .audio_valid(v15), .locked(lk15), .frame_err(fe15)
    );
    sound_i2s_rx #(.CHANNEL_WIDTH(16), .SIGNED_OUTPUT(1'b1), .SCLK_TIMEOUT(256)) u_s16 (
        .clk_74a(clk), .reset_n(reset_n), .i2s_sclk(sclk), .i2s_lrck(lrck), .i2s_data(data),
        .audio_l(l16), .audio_r(r16), .audio_valid(v16), .locked(lk16), .frame_err(fe16)
    );
    sound_i2s_rx #(.CHANNEL_WIDTH(12), .SIGNED_OUTPUT(1'b1), .SCLK_TIMEOUT(256)) u_s12 (
        .clk_74a(clk), .reset_n(reset_n), .i2s_sclk(sclk), .i2s_lrck(lrck), .i2s_data(data),
        .audio_l(l12), .audio_r(r12), .audio_valid(v12), .locked(lk12), .frame_err(fe12)
    );

    typedef struct {
        logic [14:0] l15, r15;
        logic [15:0] l16, r16;
        logic [11:0] l12, r12;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   fe_cnt = 0;
    int   half_p = 12;
    logic carry = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Hand-computed mappings: unsigned 15-bit drops bit 15, signed 12-bit keeps the top 12.
    function automatic void lookup(input logic [15:0] w, output logic [14:0] u,
                                   output logic [11:0] s);
        case (w)
            16'h1234: begin u = 15'h1234; s = 12'h123; end
            16'h0ABC: begin u = 15'h0ABC; s = 12'h0AB; end
            16'h8001: begin u = 15'h0001; s = 12'h800; end
            16'h7FFF: begin u = 15'h7FFF; s = 12'h7FF; end
            16'hABCD: begin u = 15'h2BCD; s = 12'hABC; end
            16'h5678: begin u = 15'h5678; s = 12'h567; end
            16'h3333: begin u = 15'h3333; s = 12'h333; end
            16'h4444: begin u = 15'h4444; s = 12'h444; end
            16'h5555: begin u = 15'h5555; s = 12'h555; end
            16'h6666: begin u = 15'h6666; s = 12'h666; end
            16'h2468: begin u = 15'h2468; s = 12'h246; end
            16'h1357: begin u = 15'h1357; s = 12'h135; end
            default:  begin u = 'x; s = 'x; end
        endcase
    endfunction

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        exp_t e;
        lookup(l, e.l15, e.l12);
        lookup(r, e.r15, e.r12);
        e.l16 = l;
        e.r16 = r;
        exp_q.push_back(e);
    endtask

    function automatic logic bit_of(input logic [15:0] w, input int p);
        if (p < 16) return w[15-p];
        return 1'b0;
    endfunction

    task automatic strobe(input logic lr, input logic d);
        @(posedge clk);
        #1;
        sclk = 1'b0;
        lrck = lr;
        data = d;
        repeat (half_p) @(posedge clk);
        #1 sclk = 1'b1;
        repeat (half_p - 1) @(posedge clk);
    endtask

    // First strobe of a slot carries the previous slot's last bit (one-bit I2S delay).
    task automatic send_slot(input logic lr, input logic [15:0] w, input int len);
        strobe(lr, carry);
        for (int p = 0; p < len - 1; p++) strobe(lr, bit_of(w, p));
        carry = bit_of(w, len - 1);
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int rlen,
                              input bit emit);
        send_slot(1'b0, l, 32);
        send_slot(1'b1, r, rlen);
        if (emit) push(l, r);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        sclk = 1'b0;
        reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        carry = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        @(negedge clk);
        check({tag, "_l15"}, 32'(l15), 32'h0);
        check({tag, "_r15"}, 32'(r15), 32'h0);
        check({tag, "_l16"}, 32'(l16), 32'h0);
        check({tag, "_r12"}, 32'(r12), 32'h0);
        check({tag, "_valid"}, 32'(v15), 32'h0);
        check({tag, "_locked"}, 32'(lk15), 32'h0);
        check({tag, "_frame_err"}, 32'(fe15), 32'h0);
    endtask

    always @(negedge clk) begin
        if (fe15) fe_cnt++;
        if (v15 || v16 || v12) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid: got valid with l15=%h r15=%h, expected none",
                         l15, r15);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("valid_all", {v15, v16, v12}, 32'h7);
                check("pair_l15", 32'(l15), 32'(e.l15));
                check("pair_r15", 32'(r15), 32'(e.r15));
                check("pair_l16", 32'(l16), 32'(e.l16));
                check("pair_r16", 32'(r16), 32'(e.r16));
                check("pair_l12", 32'(l12), 32'(e.l12));
                check("pair_r12", 32'(r12), 32'(e.r12));
            end
        end
    end

    initial begin
        repeat (4) @(posedge clk);
        #1 reset_n = 1'b1;
        check_zero("reset");

        // Nominal stream: lock after the second completed slot, first pair in frame 3.
        send_frame(16'h1234, 16'h0ABC, 32, 1'b0);
        @(negedge clk) check("lock_frame1", 32'(lk15), 32'h0);
        send_frame(16'h1234, 16'h0ABC, 32, 1'b1);
        @(negedge clk) check("lock_frame2", 32'(lk15), 32'h1);
        send_frame(16'h8001, 16'h7FFF, 32, 1'b1);
        send_frame(16'hABCD, 16'h5678, 32, 1'b1);

        // Short right slot: frame dropped, relock after two good slots.
        send_frame(16'h1111, 16'h2222, 10, 1'b0);
        send_frame(16'h3333, 16'h4444, 32, 1'b1);
        @(negedge clk) check("lock_after_short", 32'(lk15), 32'h0);
        check("frame_err_count", 32'(fe_cnt), 32'd1);
        send_frame(16'h5555, 16'h6666, 32, 1'b1);
        @(negedge clk) check("lock_recovered", 32'(lk15), 32'h1);
        send_slot(1'b0, 16'h0000, 8);

        // Timeout: SCLK parked low.
        @(posedge clk);
        #1 sclk = 1'b0;
        repeat (225) @(posedge clk);
        @(negedge clk) check("lock_before_timeout", 32'(lk15), 32'h1);
        repeat (30) @(posedge clk);
        @(negedge clk) check("lock_after_timeout", 32'(lk15), 32'h0);
        check("hold_l15", 32'(l15), 32'h5555);
        check("hold_r15", 32'(r15), 32'h6666);

        // Resume mid-slot: partial right slot is ignored.
        send_slot(1'b1, 16'hFFFF, 20);
        send_frame(16'h2468, 16'h1357, 32, 1'b1);

        // Reset at bit 7 of a left slot.
        send_slot(1'b0, 16'h9999, 8);
        pulse_reset();
        check_zero("midreset");
        send_frame(16'h5678, 16'hABCD, 32, 1'b0);
        send_frame(16'h0ABC, 16'h1234, 32, 1'b1);
        @(negedge clk) check("lock_post_reset", 32'(lk15), 32'h1);
        send_slot(1'b0, 16'h0000, 4);

        // Minimum SCLK phase of 3 cycles.
        half_p = 3;
        pulse_reset();
        send_frame(16'h1234, 16'h0ABC, 32, 1'b0);
        send_frame(16'h1234, 16'h0ABC, 32, 1'b1);
        send_slot(1'b0, 16'h0000, 4);
        @(negedge clk) check("lock_min_phase", 32'(lk15), 32'h1);

        repeat (20) @(posedge clk);
        @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("frame_err_total", 32'(fe_cnt), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
